alu_addsub_seq: RTL and testbench
=================================

Name: alu_addsub_seq

Overview:
- Multi-cycle 64-bit add/subtract unit for the sequential Y-86 execute stage.
- Computes the additive direction (a + b) as well as a - b. Subtraction is formed as a + ~b + 1.
- Result is built CHUNK bits per cycle, so the carry chain is spread over WIDTH/CHUNK cycles.
- Produces the result plus carry and Y-86 condition codes (ZF, SF, OF), with valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 64: operand and result width.
- CHUNK, 16: bits computed per cycle. WIDTH must be a multiple of CHUNK.
- NCHUNK, WIDTH/CHUNK (derived, local): number of compute cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept operands.
- in_a  in  WIDTH  operand a, two's complement.
- in_b  in  WIDTH  operand b, two's complement.
- in_op  in  1  0 = ADD (a+b), 1 = SUB (a-b).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  a+b or a-b, modulo 2^WIDTH.
- out_carry  out  1  carry out of the MSB. For SUB, 1 = no borrow.
- out_zf  out  1  out_result == 0.
- out_sf  out  1  out_result[WIDTH-1].
- out_of  out  1  signed overflow.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge.
- States: IDLE, CALC, DONE.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, all flags 0, chunk index 0.
- IDLE:
  - in_ready = 1.
  - On in_valid, at that edge capture a, b^{WIDTH{op}} (b inverted for SUB), op, and carry_in = op (1 for SUB). Set index = 0 and go to CALC.
- CALC:
  - in_ready = 0.
  - Each cycle, add chunk[index] of a and the stored b with the running carry. Store the CHUNK-bit sum and carry out, then increment index.
  - After chunk NCHUNK-1, latch the final carry, compute the flags and go to DONE.
  - Inputs are ignored in CALC; operands were captured at acceptance.
- DONE:
  - out_valid = 1. out_result and flags are held stable until out_ready is sampled 1.
  - On that edge, out_valid drops to 0 and the state returns to IDLE.
  - in_ready = 0 in DONE; there is no overlap between results.
- Latency: operands accepted at edge E0 give out_valid = 1 after edge E0+NCHUNK (4 cycles at the defaults).
- Throughput: one operation per NCHUNK+2 cycles minimum.
- Overflow rule (sa, sb, sr are the sign bits of a, original b and result):
  - ADD: OF = (sa == sb) && (sr != sa).
  - SUB: OF = (sa != sb) && (sr != sa).
- ZF and SF are computed from the full assembled result, never from a partial one.
- Reset mid-operation (CALC or DONE): the operation is abandoned, all outputs return to their reset values, and no partial result is ever presented.
- Simultaneous out_ready and a new in_valid while in DONE: the new operand is not accepted (in_ready = 0). It can be accepted in IDLE on the next cycle.
- out_ready high while not in DONE: no effect.

Decomposition:
- Package alu_pkg: ALU_ADD = 1'b0, ALU_SUB = 1'b1, state encoding (IDLE/CALC/DONE), default WIDTH/CHUNK constants.
- Sub-module add_chunk: combinational CHUNK-bit adder. Inputs a, b, cin; outputs sum, cout. Instantiated once and reused each CALC cycle.

Test Plan:
- ADD 0x1 + 0xFFFF_FFFF_FFFF_FFFF -> result 0, carry 1, zf 1, sf 0, of 0. out_valid rises exactly 4 cycles after acceptance.
- SUB 1 - 3 -> result 0xFFFF_FFFF_FFFF_FFFE, carry 0, zf 0, sf 1, of 0. SUB -1 - -3 -> result 2, carry 1, zf 0, sf 0, of 0.
- Overflow cases:
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, of 1, sf 1, carry 0.
  - SUB 0x8000_0000_0000_0000 - 1 -> result 0x7FFF_FFFF_FFFF_FFFF, of 1, sf 0, carry 1.
- Cross-chunk carry: ADD 0x0000_0000_FFFF_FFFF + 1 -> result 0x0000_0001_0000_0000. Carry must ripple through chunk boundaries at bits 16 and 32.
- Backpressure: hold out_ready low 3 cycles in DONE -> out_valid, out_result and flags stay constant, and in_ready stays 0. Raise out_ready -> next cycle out_valid 0, in_ready 1.
- Reset during CALC (2 cycles after acceptance): the next cycle shows out_valid 0, in_ready 1 and out_result 0. A following ADD 5 + 7 returns 12 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential add/subtract unit:
//   - operation encoding (ALU_ADD / ALU_SUB) carried on in_op
//   - control state encoding for the three-state sequencer
//   - default operand width and per-cycle chunk width
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_CHUNK = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage : alu_pkg

// File: rtl/add_chunk.sv
// ----------------------------------------------------------------------------
// add_chunk
// Combinational W-bit adder slice with carry in and carry out. The sequencer
// reuses a single instance every compute cycle on successive operand chunks.
// Ports:
//   a    in  W  addend chunk
//   b    in  W  addend chunk (already inverted by the caller for subtraction)
//   cin  in  1  carry into bit 0
//   sum  out W  chunk sum
//   cout out 1  carry out of bit W-1
// ----------------------------------------------------------------------------
module add_chunk #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] total_s;

   // Widen by one bit so the carry out falls into the top position.
   assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum     = total_s[W-1:0];
   assign cout    = total_s[W];

endmodule : add_chunk

// File: rtl/alu_addsub_seq.sv
// ----------------------------------------------------------------------------
// alu_addsub_seq
// Multi-cycle add/subtract unit for the sequential Y-86 execute stage. The
// sum is built CHUNK bits per cycle over NCHUNK cycles; subtraction is formed
// as a + ~b + 1. Produces result, carry and Y-86 condition codes.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands and op are valid
//   in_ready   out 1      unit can accept operands (IDLE only)
//   in_a       in  WIDTH  operand a
//   in_b       in  WIDTH  operand b
//   in_op      in  1      0 = ADD, 1 = SUB
//   out_valid  out 1      result and flags are valid (DONE)
//   out_ready  in  1      consumer accepts the result
//   out_result out WIDTH  a+b or a-b modulo 2^WIDTH
//   out_carry  out 1      carry out of the MSB (SUB: 1 = no borrow)
//   out_zf     out 1      result is zero
//   out_sf     out 1      result sign bit
//   out_of     out 1      signed overflow
// All outputs are driven straight from registers.
// ----------------------------------------------------------------------------
module alu_addsub_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zf,
   output logic             out_sf,
   output logic             out_of
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   // ---- registered state -------------------------------------------------
   alu_state_t       state_r,      state_nxt;
   logic [IDX_W-1:0] idx_r,        idx_nxt;
   // Operand shift registers: the chunk being added is always the low CHUNK bits.
   logic [WIDTH-1:0] a_r,          a_nxt;
   logic [WIDTH-1:0] b_r,          b_nxt;
   logic             carry_r,      carry_nxt;
   // Partial sum, filled from the top so chunk 0 ends up in the low bits.
   logic [WIDTH-1:0] acc_r,        acc_nxt;
   // Sign of a and sign of the effective (possibly inverted) b.
   logic             sa_r,         sa_nxt;
   logic             sb_r,         sb_nxt;
   logic             in_ready_r,   in_ready_nxt;
   logic             out_valid_r,  out_valid_nxt;
   logic [WIDTH-1:0] out_result_r, out_result_nxt;
   logic             out_carry_r,  out_carry_nxt;
   logic             out_zf_r,     out_zf_nxt;
   logic             out_sf_r,     out_sf_nxt;
   logic             out_of_r,     out_of_nxt;

   // ---- chunk adder ------------------------------------------------------
   logic [CHUNK-1:0] sum_s;
   logic             cout_s;
   logic [WIDTH-1:0] acc_shift_s;

   add_chunk #(.W(CHUNK)) u_add_chunk (
      .a    (a_r[CHUNK-1:0]),
      .b    (b_r[CHUNK-1:0]),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Accumulator after inserting this cycle's chunk sum at the top.
   always_comb begin
      acc_shift_s                    = acc_r >> CHUNK;
      acc_shift_s[WIDTH-1 -: CHUNK]  = sum_s;
   end

   // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_nxt      = state_r;
      idx_nxt        = idx_r;
      a_nxt          = a_r;
      b_nxt          = b_r;
      carry_nxt      = carry_r;
      acc_nxt        = acc_r;
      sa_nxt         = sa_r;
      sb_nxt         = sb_r;
      in_ready_nxt   = in_ready_r;
      out_valid_nxt  = out_valid_r;
      out_result_nxt = out_result_r;
      out_carry_nxt  = out_carry_r;
      out_zf_nxt     = out_zf_r;
      out_sf_nxt     = out_sf_r;
      out_of_nxt     = out_of_r;

      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt    = ST_CALC;
               in_ready_nxt = 1'b0;
               idx_nxt      = '0;
               a_nxt        = in_a;
               // SUB: a + ~b + 1, the +1 enters as the initial carry.
               b_nxt        = in_b ^ {WIDTH{in_op == ALU_SUB}};
               carry_nxt    = (in_op == ALU_SUB);
               acc_nxt      = '0;
               sa_nxt       = in_a[WIDTH-1];
               // With b's sign folded through the inversion, the ADD rule
               // (equal input signs, different result sign) also covers SUB.
               sb_nxt       = in_b[WIDTH-1] ^ (in_op == ALU_SUB);
            end else begin
               state_nxt    = ST_IDLE;
            end
         end

         ST_CALC: begin
            a_nxt     = a_r >> CHUNK;
            b_nxt     = b_r >> CHUNK;
            carry_nxt = cout_s;
            acc_nxt   = acc_shift_s;
            if (idx_r == LAST_IDX) begin
               state_nxt      = ST_DONE;
               idx_nxt        = '0;
               out_valid_nxt  = 1'b1;
               out_result_nxt = acc_shift_s;
               out_carry_nxt  = cout_s;
               out_zf_nxt     = (acc_shift_s == {WIDTH{1'b0}});
               out_sf_nxt     = acc_shift_s[WIDTH-1];
               out_of_nxt     = (sa_r == sb_r) && (acc_shift_s[WIDTH-1] != sa_r);
            end else begin
               state_nxt      = ST_CALC;
               idx_nxt        = idx_r + IDX_W'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_nxt     = ST_IDLE;
               out_valid_nxt = 1'b0;
               in_ready_nxt  = 1'b1;
            end else begin
               state_nxt     = ST_DONE;
            end
         end

         default: begin
            state_nxt     = ST_IDLE;
            in_ready_nxt  = 1'b1;
            out_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= '0;
         a_r          <= '0;
         b_r          <= '0;
         carry_r      <= 1'b0;
         acc_r        <= '0;
         sa_r         <= 1'b0;
         sb_r         <= 1'b0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         out_result_r <= '0;
         out_carry_r  <= 1'b0;
         out_zf_r     <= 1'b0;
         out_sf_r     <= 1'b0;
         out_of_r     <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         idx_r        <= idx_nxt;
         a_r          <= a_nxt;
         b_r          <= b_nxt;
         carry_r      <= carry_nxt;
         acc_r        <= acc_nxt;
         sa_r         <= sa_nxt;
         sb_r         <= sb_nxt;
         in_ready_r   <= in_ready_nxt;
         out_valid_r  <= out_valid_nxt;
         out_result_r <= out_result_nxt;
         out_carry_r  <= out_carry_nxt;
         out_zf_r     <= out_zf_nxt;
         out_sf_r     <= out_sf_nxt;
         out_of_r     <= out_of_nxt;
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign out_result = out_result_r;
   assign out_carry  = out_carry_r;
   assign out_zf     = out_zf_r;
   assign out_sf     = out_sf_r;
   assign out_of     = out_of_r;

endmodule : alu_addsub_seq

// File: tb/tb_alu_addsub_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_addsub_seq
// Self-checking bench for alu_addsub_seq: a vector table (directed plus
// random), then hand-written backpressure and mid-operation reset sequences.
// Expected results are queued when operands are driven and popped when the
// unit presents a result.
// ----------------------------------------------------------------------------
module tb_alu_addsub_seq;
   import alu_pkg::*;

   localparam int WIDTH  = 64;
   localparam int CHUNK  = 16;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int NVEC   = 14;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_zf;
   logic             out_sf;
   logic             out_of;

   alu_addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_zf     (out_zf),
      .out_sf     (out_sf),
      .out_of     (out_of)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             carry;
      logic             zf;
      logic             sf;
      logic             of;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t exp_q[$];
   vec_t tbl[NVEC];

   // Reference model: plain arithmetic, borrow via unsigned compare.
   function automatic vec_t model(input logic op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      vec_t           v;
      logic [WIDTH:0] s;
      v.op = op;
      v.a  = a;
      v.b  = b;
      if (op == ALU_SUB) begin
         v.res   = a - b;
         v.carry = (a >= b);
         v.of    = (a[WIDTH-1] != b[WIDTH-1]) && (v.res[WIDTH-1] != a[WIDTH-1]);
      end else begin
         s       = {1'b0, a} + {1'b0, b};
         v.res   = s[WIDTH-1:0];
         v.carry = s[WIDTH];
         v.of    = (a[WIDTH-1] == b[WIDTH-1]) && (v.res[WIDTH-1] != a[WIDTH-1]);
      end
      v.zf = (v.res == 64'd0);
      v.sf = v.res[WIDTH-1];
      return v;
   endfunction

   task automatic chk(input string name, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Waits (bounded) for in_ready, presents one operation, pushes its
   // expectation at the accepting edge. Returns at the negedge after acceptance.
   task automatic drive_op(input string tag, input vec_t e);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_in_ready_idle"}, in_ready, 64'd1);
      in_valid = 1'b1;
      in_op    = e.op;
      in_a     = e.a;
      in_b     = e.b;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble operands: the unit must use its captured copies.
      in_a     = ~e.a;
      in_b     = ~e.b;
      in_op    = ~e.op;
      chk({tag, "_in_ready_busy"}, in_ready, 64'd0);
   endtask

   // Waits for out_valid, checks latency and fields, then completes the handshake.
   task automatic collect(input string tag);
      int   lat = 0;
      vec_t e;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(NCHUNK));
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_result"}, out_result, e.res);
         chk({tag, "_carry"},  64'(out_carry), 64'(e.carry));
         chk({tag, "_zf"},     64'(out_zf),    64'(e.zf));
         chk({tag, "_sf"},     64'(out_sf),    64'(e.sf));
         chk({tag, "_of"},     64'(out_of),    64'(e.of));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready_back"},  64'(in_ready),  64'd1);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      int   lat;

      // Directed vectors from the plan, plus chunk-boundary and zero cases.
      tbl[0] = '{ALU_ADD, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{ALU_SUB, 64'h1, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE,
                 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'h2,
                 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000,
                 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{ALU_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF,
                 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{ALU_ADD, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000,
                 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{ALU_SUB, 64'h5, 64'h5, 64'h0,
                 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{ALU_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000,
                 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 8; i < NVEC; i++) begin
         tbl[i] = model(1'($urandom_range(1, 0)), {$urandom, $urandom}, {$urandom, $urandom});
      end

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_a      = 64'd0;
      in_b      = 64'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready",   64'(in_ready),  64'd1);
      chk("reset_out_valid",  64'(out_valid), 64'd0);
      chk("reset_out_result", out_result,     64'd0);
      chk("reset_flags",      64'({out_carry, out_zf, out_sf, out_of}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < NVEC; i++) begin
         drive_op($sformatf("v%0d", i), tbl[i]);
         collect($sformatf("v%0d", i));
      end

      // Backpressure: result must hold for 3 cycles, then a new operand
      // offered together with out_ready must not be taken in DONE.
      e = model(ALU_SUB, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      drive_op("bp", e);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'(NCHUNK));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", k),  64'(out_valid), 64'd1);
         chk($sformatf("bp_hold%0d_result", k), out_result,     e.res);
         chk($sformatf("bp_hold%0d_flags", k),
             64'({out_carry, out_zf, out_sf, out_of}),
             64'({e.carry, e.zf, e.sf, e.of}));
         chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = ALU_ADD;
      in_a      = 64'd9;
      in_b      = 64'd9;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      void'(exp_q.pop_front());
      chk("bp_release_valid",    64'(out_valid), 64'd0);
      chk("bp_release_in_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      chk("bp_not_accepted", 64'(in_ready), 64'd1);

      // Reset two cycles after acceptance abandons the operation.
      e = model(ALU_ADD, 64'd100, 64'd200);
      drive_op("rst", e);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("rst_mid_out_valid",  64'(out_valid), 64'd0);
      chk("rst_mid_in_ready",   64'(in_ready),  64'd1);
      chk("rst_mid_out_result", out_result,     64'd0);
      repeat (NCHUNK + 1) @(negedge clk);
      chk("rst_mid_no_result", 64'(out_valid), 64'd0);

      e = '{ALU_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0, 1'b0};
      drive_op("after_rst", e);
      collect("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_addsub_seq
